// File: rtl/inv_sbox_if.sv
// Start/done handshake bundle for the inverse S-box engine; start is a level sampled only when idle,
// done is a one-cycle completion strobe, no backpressure on the result bus.
interface inv_sbox_if #(
  parameter int NUM_BYTES = 16
) ();
  logic                   start;
  logic [8*NUM_BYTES-1:0] state_in;
  logic                   busy;
  logic                   done;
  logic [8*NUM_BYTES-1:0] state_out;

  modport master (
    output start,
    output state_in,
    input  busy,
    input  done,
    input  state_out
  );

  modport slave (
    input  start,
    input  state_in,
    output busy,
    output done,
    output state_out
  );
endinterface

// File: rtl/inv_sbox_engine.sv
// Byte-serial AES inverse SubBytes via InvAffine then x^254 on one shared GF(2^8) square/multiply pair;
// 8 cycles per byte, done one cycle after accept+8*NUM_BYTES; start ignored unless idle, no output stall.
module inv_sbox_engine #(
  parameter int NUM_BYTES = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  inv_sbox_if.slave bus
);

  localparam int              IDXW     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXP,
    ST_DONE
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [NUM_BYTES-1:0][7:0] in_reg;
  logic [NUM_BYTES-1:0][7:0] res_reg;
  logic [NUM_BYTES-1:0][7:0] out_reg;
  logic [NUM_BYTES-1:0][7:0] merged;
  logic [IDXW-1:0]           idx;
  logic [2:0]                step;
  logic [7:0]                sq;
  logic [7:0]                acc;
  logic [7:0]                x;
  logic [7:0]                s2;
  logic [7:0]                p;
  logic                      step_last;
  logic                      idx_last;
  logic                      busy;
  logic                      done;

  // Carry-less product reduced by x^8+x^4+x^3+x+1 one shift at a time.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  assign x         = inv_affine(in_reg[idx]);
  assign s2        = gf_mul(sq, sq);
  assign p         = gf_mul(acc, s2);
  assign step_last = (step == 3'd6);
  assign idx_last  = (idx == LAST_IDX);

  always_comb begin
    merged      = res_reg;
    merged[idx] = p;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_EXP;
      ST_EXP:  if (step_last) state_d = idx_last ? ST_DONE : ST_LOAD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_LOAD) || (state_q == ST_EXP);
    done = (state_q == ST_DONE);
  end

  // sq walks x^2, x^4 .. x^128 while acc collects their product, ending at x^254.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_reg  <= '0;
      res_reg <= '0;
      out_reg <= '0;
      idx     <= '0;
      step    <= '0;
      sq      <= '0;
      acc     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            in_reg <= bus.state_in;
            idx    <= '0;
          end
        end
        ST_LOAD: begin
          sq   <= x;
          acc  <= 8'h01;
          step <= 3'd0;
        end
        ST_EXP: begin
          sq <= s2;
          if (step_last) begin
            res_reg[idx] <= p;
            if (idx_last) out_reg <= merged;
            else          idx     <= idx + 1'b1;
          end else begin
            acc  <= p;
            step <= step + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.state_out = out_reg;

endmodule

// File: tb/tb_inv_sbox_engine.sv
// Randomised scoreboard bench for inv_sbox_engine against a log/antilog-table AES S-box model.
module tb_inv_sbox_engine;

  localparam int NB  = 16;
  localparam int W   = 8 * NB;
  localparam int LAT = 8 * NB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_sbox_if #(.NUM_BYTES(NB)) bus ();

  inv_sbox_engine #(.NUM_BYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [7:0]   sbox_tab[256];
  logic [7:0]   inv_tab[256];
  int           cyc       = 0;
  int           n_vec     = 0;
  int           n_err     = 0;
  int           busy_cnt  = 0;
  int           last_done = -1;
  int           prev_done = -1;
  logic [W-1:0] last_out  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  // Forward S-box from inverse-by-logarithm plus the forward affine map; the inverse table is its transpose.
  task automatic build_tables();
    logic [7:0] alog[256];
    int         lg[256];
    logic [7:0] t;
    logic [7:0] v;
    t = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog[i] = t;
      lg[t]   = i;
      t       = t ^ xt(t);
    end
    for (int a = 0; a < 256; a++) begin
      v = (a == 0) ? 8'h00 : alog[(255 - lg[a]) % 255];
      sbox_tab[a] = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) inv_tab[sbox_tab[a]] = 8'(a);
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] s);
    logic [W-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) begin
        busy_cnt++;
        check("hold_state_out", bus.state_out, last_out);
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done at cycle %0d: got done=1, expected done=0", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("state_out", bus.state_out, mon_e.dout);
          check("done_latency", W'(cyc), W'(mon_e.due));
          check("busy_cycles", W'(busy_cnt), W'(LAT));
          for (int i = 0; i < NB; i++)
            check("sbox_roundtrip", W'(sbox_tab[bus.state_out[8*i +: 8]]), W'(mon_e.din[8*i +: 8]));
          last_out = mon_e.dout;
        end
        busy_cnt  = 0;
        prev_done = last_done;
        last_done = cyc;
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] s, input logic [W-1:0] e);
    exp_t it;
    it.din  = s;
    it.dout = e;
    it.due  = cyc + LAT;
    exp_q.push_back(it);
  endtask

  task automatic issue(input logic [W-1:0] s, input logic [W-1:0] e);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.state_in = s;
    @(negedge clk);
    push_exp(s, e);
    bus.start    = 1'b0;
    bus.state_in = rnd_state();
  endtask

  task automatic drain();
    for (int k = 0; k < 3 * LAT; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout at cycle %0d: got %0d pending, expected 0", cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [W-1:0] s;
    logic [W-1:0] s2;
    logic [W-1:0] e;
    logic [7:0]   pin[4];
    logic [7:0]   pout[4];
    bit           seen;

    pin  = '{8'hFF, 8'hED, 8'h7C, 8'h00};
    pout = '{8'h7D, 8'h53, 8'h01, 8'h52};
    bus.start    = 1'b0;
    bus.state_in = '0;
    build_tables();

    repeat (3) @(negedge clk);
    check("reset_busy", W'(bus.busy), '0);
    check("reset_done", W'(bus.done), '0);
    check("reset_state_out", bus.state_out, '0);
    rst_n = 1'b1;

    // Constant patterns with literal expectations
    issue({NB{8'h63}}, '0);
    drain();
    for (int i = 0; i < NB; i++) begin
      s[8*i +: 8] = pin[i % 4];
      e[8*i +: 8] = pout[i % 4];
    end
    issue(s, e);
    drain();

    // Every byte value, spread across byte lanes
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NB; i++) s[8*i +: 8] = 8'(16 * i + ((k + i) % 16));
      issue(s, model(s));
      drain();
    end

    repeat (4) begin
      s = rnd_state();
      issue(s, model(s));
      drain();
    end

    // Start held and toggled through busy and done; only the first capture counts
    s = rnd_state();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.state_in = s;
    @(negedge clk);
    push_exp(s, model(s));
    seen = 1'b0;
    for (int k = 0; k < 3 * LAT; k++) begin
      @(negedge clk);
      if (bus.done) begin
        bus.start = 1'b1;
        seen      = 1'b1;
      end else if (seen) begin
        bus.start = 1'b0;
        break;
      end else begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.state_in = rnd_state();
      end
    end
    bus.start = 1'b0;
    check("held_start_done_seen", W'(seen), W'(1));
    repeat (10) @(negedge clk);
    check("held_start_no_reaccept", W'(bus.busy), '0);
    drain();

    // Reset mid-operation aborts without a done pulse
    s = rnd_state();
    issue(s, model(s));
    repeat (59) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(bus.busy), '0);
    check("abort_done", W'(bus.done), '0);
    check("abort_state_out", bus.state_out, '0);
    exp_q.delete();
    last_out = '0;
    rst_n = 1'b1;
    repeat (LAT + 20) @(negedge clk);
    s = rnd_state();
    issue(s, model(s));
    drain();

    // Back-to-back: restart in the idle cycle right after done
    s  = rnd_state();
    s2 = rnd_state();
    issue(s, model(s));
    seen = 1'b0;
    for (int k = 0; k < 3 * LAT; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_first_done_seen", W'(seen), W'(1));
    bus.start    = 1'b1;
    bus.state_in = s2;
    @(negedge clk);
    @(negedge clk);
    push_exp(s2, model(s2));
    bus.start    = 1'b0;
    bus.state_in = rnd_state();
    drain();
    check("b2b_done_gap", W'(last_done - prev_done), W'(LAT + 2));

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got no end of test, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
